// File: rtl/jpeg_dec_pkg.sv
// Shared definitions for the JPEG decode path: buffer/window widths,
// bit-count types and the end-of-stream fill mask helper.
package jpeg_dec_pkg;

   localparam int WIN_W = 32;
   localparam int BUF_W = 64;

   // 0..64 bits held in the shift buffer
   typedef logic [6:0] bit_cnt_t;
   // 0..32 bits visible in the peek window
   typedef logic [5:0] win_cnt_t;

   // Ones at every window position at or beyond nbits (MSB is position 0).
   function automatic logic [WIN_W-1:0] eos_mask(input win_cnt_t nbits);
      return {WIN_W{1'b1}} >> nbits;
   endfunction

endpackage

// File: rtl/bit_unpack_if.sv
// Stream-in / window-out bundle of the bit unpacker. The slave side is
// the unpacker itself; the master side is upstream producer plus consumer.
interface bit_unpack_if;

   logic [31:0] in_data;
   logic [2:0]  in_nbytes;
   logic        in_tlast;
   logic        in_valid;
   logic        in_hold;
   logic [31:0] out_data;
   logic [5:0]  out_nbits;
   logic        out_tlast;
   logic        out_valid;
   logic        take_valid;
   logic [5:0]  take_nbits;
   logic        err_overrun;

   modport slave (
      input  in_data, in_nbytes, in_tlast, in_valid, take_valid, take_nbits,
      output in_hold, out_data, out_nbits, out_tlast, out_valid, err_overrun
   );

   modport master (
      output in_data, in_nbytes, in_tlast, in_valid, take_valid, take_nbits,
      input  in_hold, out_data, out_nbits, out_tlast, out_valid, err_overrun
   );

endinterface

// File: rtl/bit_unpack.sv
// Bit unpacker: accepts MSB-first byte-counted words into a 64-bit shift
// buffer and presents a 32-bit MSB-aligned peek window from which the
// entropy decoder consumes 1..32 bits per cycle. Outputs are purely a
// function of registered state, so neither side sees a combinational path
// from the other. Only WIN_W = 32 with BUF_W = 2*WIN_W is supported.
module bit_unpack #(
   parameter logic EOS_FILL = 1'b1,
   parameter int   WIN_W    = 32,
   parameter int   BUF_W    = 64
) (
   input  logic         clk,
   input  logic         reset,
   bit_unpack_if.slave  bus
);
   import jpeg_dec_pkg::*;

   logic [BUF_W-1:0] buf_q;
   logic [BUF_W-1:0] buf_d;
   bit_cnt_t         bit_count_q;
   bit_cnt_t         bit_count_d;
   logic             last_q;
   logic             last_d;
   logic             err_q;
   logic             err_d;

   logic             out_valid_w;
   win_cnt_t         out_nbits_w;
   logic             out_tlast_w;
   logic             in_hold_w;
   logic             accept;
   logic [2:0]       nbytes_c;
   bit_cnt_t         load;
   win_cnt_t         eff_take;
   bit_cnt_t         rem;
   logic [WIN_W-1:0] in_masked;
   logic [BUF_W-1:0] keep_mask;
   logic [WIN_W-1:0] win;
   logic [WIN_W-1:0] fill_mask;
   logic [WIN_W-1:0] out_data_w;

   function automatic win_cnt_t min_cnt(input win_cnt_t a, input win_cnt_t b);
      return (a < b) ? a : b;
   endfunction

   // Window status and back-pressure, derived only from registered state
   always_comb begin
      out_valid_w = (bit_count_q >= 7'd32) | (last_q & (bit_count_q != 7'd0));
      out_nbits_w = (bit_count_q >= 7'd32) ? 6'd32 : bit_count_q[5:0];
      out_tlast_w = last_q & (bit_count_q <= 7'd32) & (bit_count_q != 7'd0);
      // Holding above 32 bits guarantees a whole word always fits after the merge
      in_hold_w   = (bit_count_q > 7'd32) | last_q;
   end

   // Consume/load arithmetic and next-state buffer merge
   always_comb begin
      accept    = bus.in_valid & ~in_hold_w;
      nbytes_c  = (bus.in_nbytes > 3'd4) ? 3'd4 : bus.in_nbytes;
      load      = accept ? {1'b0, nbytes_c, 3'b000} : 7'd0;
      eff_take  = (bus.take_valid & out_valid_w) ?
                  min_cnt(bus.take_nbits, out_nbits_w) : 6'd0;
      rem       = bit_count_q - {1'b0, eff_take};
      // Drop bytes beyond in_nbytes so they cannot pollute the merge
      in_masked = bus.in_data & ~({WIN_W{1'b1}} >> load);
      // Keep only live bits; stale buffer contents below rem never leak through
      keep_mask = ~({BUF_W{1'b1}} >> rem);
      buf_d     = ((buf_q << eff_take) & keep_mask) |
                  ({in_masked, {WIN_W{1'b0}}} >> rem);
      bit_count_d = rem + load;
      last_d    = (last_q | (accept & bus.in_tlast)) & (bit_count_d != 7'd0);
      err_d     = err_q | (bus.take_valid & (~out_valid_w |
                                            (bus.take_nbits > out_nbits_w) |
                                            (bus.take_nbits == 6'd0)));
   end

   // Window data with end-of-stream padding beyond the last valid bit
   always_comb begin
      win        = buf_q[BUF_W-1 -: WIN_W];
      fill_mask  = eos_mask(out_nbits_w);
      out_data_w = out_tlast_w ?
                   ((win & ~fill_mask) | ({WIN_W{EOS_FILL}} & fill_mask)) : win;
   end

   // Control state: bit count, end-of-stream and sticky error flags
   always_ff @(posedge clk) begin
      if (reset) begin
         bit_count_q <= 7'd0;
         last_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         bit_count_q <= bit_count_d;
         last_q      <= last_d;
         err_q       <= err_d;
      end
   end

   // Shift buffer data; contents are qualified by bit_count so no reset needed
   always_ff @(posedge clk) begin
      buf_q <= buf_d;
   end

   assign bus.in_hold     = in_hold_w;
   assign bus.out_data    = out_data_w;
   assign bus.out_nbits   = out_nbits_w;
   assign bus.out_tlast   = out_tlast_w;
   assign bus.out_valid   = out_valid_w;
   assign bus.err_overrun = err_q;

endmodule

// File: tb/tb_bit_unpack.sv
// Directed testbench for bit_unpack with a cycle-stamped scoreboard.
module tb_bit_unpack;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   bit_unpack_if bus ();

   bit_unpack dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      string       name;
      int          cyc;
      logic        v;
      logic [5:0]  n;
      logic        t;
      logic [31:0] d;
      logic        h;
      logic        e;
   } exp_t;

   exp_t q[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compare each expectation in the cycle it was stamped for
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         exp_t x;
         x = q.pop_front();
         checks++;
         if (x.cyc != cyc || bus.out_valid !== x.v || bus.out_nbits !== x.n ||
             bus.out_tlast !== x.t || bus.in_hold !== x.h || bus.err_overrun !== x.e ||
             (x.v && bus.out_data !== x.d)) begin
            errors++;
            $display("FAIL %s: got valid=%b nbits=%0d tlast=%b data=%h hold=%b err=%b, expected valid=%b nbits=%0d tlast=%b data=%h hold=%b err=%b (cyc %0d/%0d)",
                     x.name, bus.out_valid, bus.out_nbits, bus.out_tlast, bus.out_data,
                     bus.in_hold, bus.err_overrun, x.v, x.n, x.t, x.d, x.h, x.e, x.cyc, cyc);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.in_valid   = 1'b0;
      bus.in_data    = 32'h0;
      bus.in_nbytes  = 3'd0;
      bus.in_tlast   = 1'b0;
      bus.take_valid = 1'b0;
      bus.take_nbits = 6'd0;
   endtask

   task automatic push(input logic [31:0] d, input logic [2:0] nb, input logic last);
      bus.in_valid  = 1'b1;
      bus.in_data   = d;
      bus.in_nbytes = nb;
      bus.in_tlast  = last;
   endtask

   task automatic take(input logic [5:0] n);
      bus.take_valid = 1'b1;
      bus.take_nbits = n;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle();
      step();
      reset = 1'b0;
   endtask

   task automatic expect_now(input string name, input logic v, input logic [5:0] n,
                             input logic t, input logic [31:0] d, input logic h,
                             input logic e);
      exp_t x;
      x.name = name;
      x.cyc  = cyc;
      x.v    = v;
      x.n    = n;
      x.t    = t;
      x.d    = d;
      x.h    = h;
      x.e    = e;
      q.push_back(x);
   endtask

   initial begin
      reset = 1'b1;
      idle();
      step();
      step();
      reset = 1'b0;
      expect_now("reset", 0, 0, 0, 32'h0, 0, 0);

      // Load / peek / take
      push(32'hA5A5A5A5, 4, 0); step(); idle();
      expect_now("t1_first", 1, 32, 0, 32'hA5A5A5A5, 0, 0);
      push(32'h12345678, 4, 0); step(); idle();
      expect_now("t1_full", 1, 32, 0, 32'hA5A5A5A5, 1, 0);
      take(4); step(); idle();
      expect_now("t1_take4", 1, 32, 0, 32'h5A5A5A51, 1, 0);
      take(32); step(); idle();
      expect_now("t1_take32", 0, 28, 0, 32'h0, 0, 0);
      do_reset();

      // Back-pressure
      push(32'h11111111, 4, 0); step();
      push(32'h22222222, 4, 0); step();
      push(32'h33333333, 4, 0);
      expect_now("t2_hold", 1, 32, 0, 32'h11111111, 1, 0);
      take(32); step(); bus.take_valid = 1'b0;
      expect_now("t2_after_take", 1, 32, 0, 32'h22222222, 0, 0);
      step(); idle();
      expect_now("t2_w3_accepted", 1, 32, 0, 32'h22222222, 1, 0);
      take(32); step(); idle();
      expect_now("t2_window_w3", 1, 32, 0, 32'h33333333, 0, 0);
      do_reset();

      // Simultaneous take + load
      push(32'hDEADBEEF, 4, 0); step(); idle();
      expect_now("t3_load", 1, 32, 0, 32'hDEADBEEF, 0, 0);
      push(32'hCAFEF00D, 4, 0); take(12); step(); idle();
      expect_now("t3_take_load", 1, 32, 0, 32'hDBEEFCAF, 1, 0);
      take(20); step(); idle();
      expect_now("t3_rest", 1, 32, 0, 32'hCAFEF00D, 0, 0);
      do_reset();

      // Partial words and ignored zero-byte word
      push(32'hAABBCCDD, 3, 0); step(); idle();
      expect_now("pb_3bytes", 0, 24, 0, 32'h0, 0, 0);
      push(32'h11223344, 1, 0); step(); idle();
      expect_now("pb_merge", 1, 32, 0, 32'hAABBCC11, 0, 0);
      push(32'hFFFFFFFF, 0, 0); step(); idle();
      expect_now("pb_zero_ignored", 1, 32, 0, 32'hAABBCC11, 0, 0);
      do_reset();

      // Empty stream
      push(32'h0, 0, 1); step(); idle();
      expect_now("empty_stream", 0, 0, 0, 32'h0, 0, 0);

      // Tail with 1-padding
      push(32'hABC00000, 2, 1); step(); idle();
      expect_now("t4_tail", 1, 16, 1, 32'hABC0FFFF, 1, 0);
      take(16); step(); idle();
      expect_now("t4_drained", 0, 0, 0, 32'h0, 0, 0);

      // Overrun at tail, sticky error
      push(32'hABC00000, 2, 1); step(); idle();
      take(20); step(); idle();
      expect_now("t5_overrun", 0, 0, 0, 32'h0, 0, 1);
      push(32'h11111111, 4, 0); step(); idle();
      expect_now("t5_sticky", 1, 32, 0, 32'h11111111, 0, 1);

      // Reset mid-stream
      push(32'h22220000, 2, 1); step(); idle();
      expect_now("t6_midstream", 1, 32, 0, 32'h11111111, 1, 1);
      do_reset();
      expect_now("t6_reset", 0, 0, 0, 32'h0, 0, 0);
      take(1); step(); idle();
      expect_now("err_take_idle", 0, 0, 0, 32'h0, 0, 1);
      do_reset();
      push(32'h0F0F0F0F, 4, 0); step(); idle();
      expect_now("t6_new_word", 1, 32, 0, 32'h0F0F0F0F, 0, 0);

      for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain: %0d expectations left, required 0", q.size());
      end
      step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bit_unpack.md
Name: bit_unpack

Overview:
Receive-side counterpart of the JPEG encoder's bit packer. It accepts MSB-first 32-bit words with a byte count and end-of-stream flag, and presents a 32-bit MSB-aligned peek window of the bitstream. A Huffman/coefficient decoder consumes a variable number of bits (1..32) per cycle from that window. It sits between the byte-unstuffing stage and the entropy decoder in the JPEG decode path.

Parameters:
EOS_FILL, 1'b1, value of window bits beyond end of stream (matches encoder 1-padding).
WIN_W, 32, peek window width; only 32 supported, for readability.
BUF_W, 64, internal shift buffer width; must equal 2*WIN_W.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_data  in  32  stream word, first bit at [31], bytes MSB-first
in_nbytes  in  3  valid bytes in in_data, 0..4; 0 is legal only with in_tlast
in_tlast  in  1  word ends the stream
in_valid  in  1  in_data/in_nbytes/in_tlast valid
in_hold  out  1  word not accepted this cycle
out_data  out  32  window, next stream bit at [31]
out_nbits  out  6  valid bits in window, 1..32 when out_valid
out_tlast  out  1  window contains the final bit of the stream
out_valid  out  1  window usable
take_valid  in  1  consumer consumes bits this cycle
take_nbits  in  6  bits consumed, 1..32
err_overrun  out  1  sticky: take exceeded out_nbits or occurred while not out_valid

Behaviour:
- State: buf[63:0] (MSB-aligned), bit_count[6:0] (0..64), last_in_buf, err_overrun. All outputs derive combinationally from this registered state.
- Reset, and the cycle after reset: bit_count=0, last_in_buf=0, err_overrun=0, so out_valid=0, out_nbits=0, out_tlast=0, in_hold=0. Reset mid-operation discards buffered bits and any pending tlast.
- in_hold = (bit_count > 32) | last_in_buf. A word is accepted when in_valid & ~in_hold.
- Acceptance is based on the current bit_count only, not on the same-cycle take. This keeps the acceptance path free of consumer timing.
- eff_take = take_valid & out_valid ? min(take_nbits, out_nbits) : 0.
- Set err_overrun if take_valid & (~out_valid | take_nbits > out_nbits | take_nbits == 0). It is cleared only by reset.
- load = accepted ? 8*in_nbytes : 0.
- Next bit_count = bit_count - eff_take + load, always within 0..64.
- Next buf = (buf << eff_take) | ({in_data masked to load bits, 32'b0} >> (bit_count - eff_take)).
- Bits below the loaded bytes are zeroed before the merge. The shift amount is at most 32 by the hold rule.
- Accepting a word with in_tlast sets last_in_buf. last_in_buf clears when next bit_count == 0.
- Latency: a word accepted in cycle N is visible in out_data in cycle N+1. A take in cycle N advances the window in cycle N+1.
- out_valid = (bit_count >= 32) | (last_in_buf & bit_count != 0).
- out_nbits = min(bit_count, 32). The value 32 is encoded as 6'd32.
- out_tlast = last_in_buf & bit_count <= 32 & bit_count != 0.
- out_data = buf[63:32]. Bit positions at or beyond out_nbits are forced to EOS_FILL when out_tlast, otherwise they are real data.
- in_nbytes=0 with in_tlast and bit_count=0 ends an empty stream: no window is produced and last_in_buf clears the next cycle. in_nbytes=0 without in_tlast is ignored.
- Simultaneous take and load in the same cycle are both applied.
- A take of exactly out_nbits at out_tlast empties the stream: the next cycle has out_valid=0 and in_hold=0.
- No stuffing removal, marker detection, or stream restart inside this block.

Decomposition:
- Shared package jpeg_dec_pkg holds:
  - BUF_W and WIN_W
  - the bit-count type (7-bit) and window-count type (6-bit)
  - the function computing the EOS_FILL mask from out_nbits
- No sub-module. Shifter, counter and flags are one block of about 150-250 lines.

Test Plan:
- Load/peek/take: push 0xA5A5A5A5 (4B), then 0x12345678 (4B). With no take, the window shows 0xA5A5A5A5. Take 4 → next cycle out_data=0x5A5A5A51, bit_count=60.
- Back-pressure: no takes, push 3 full words. Words 1-2 are accepted (bit_count 32, then 64) and in_hold=1 on word 3. Take 32 → word 3 is accepted the cycle after bit_count reaches 32.
- Simultaneous take+load: bit_count=32 holding 0xDEADBEEF; take 12 while pushing 0xCAFEF00D → bit_count=52, out_data=0xDBEEFCAF.
- Tail: push 0xABC00000 with nbytes=2 and tlast → out_nbits=16, out_tlast=1, out_data=0xABC0FFFF, in_hold=1. Take 16 → out_valid=0 and in_hold=0 next cycle.
- Overrun: with out_nbits=16 at tail, take 20 → err_overrun=1, bit_count=0, stream ends. err_overrun stays 1 until reset.
- Reset mid-stream: bit_count=48 with last_in_buf=1, assert reset one cycle → out_valid=0, in_hold=0, err_overrun=0. A new word is accepted immediately.
